// File: rtl/apb_slave.sv
// APB completer with four 32-bit register slots (status, write-only, read-write, constant).
// Define APB_SLV_ERR_EN to drive p_slv_err on illegal accesses; otherwise p_slv_err is tied low.
module apb_slave #(
  parameter int unsigned WAIT_CYCLES = 0,
  parameter logic [31:0] FIXED_VAL   = 32'hA5A5_5A5A
) (
  input  logic        p_clk,
  input  logic        p_reset,
  input  logic        p_sel,
  input  logic        p_enable,
  input  logic        p_write,
  input  logic [1:0]  p_addr,
  input  logic [31:0] p_w_data,
  output logic        p_ready,
  output logic        p_slv_err,
  output logic [31:0] p_r_data
);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  localparam logic [3:0] LpWait = 4'(WAIT_CYCLES);

  state_e      r_state;
  logic [3:0]  r_wait_cnt;
  logic [31:0] r_reg_rw;
  logic [31:0] r_reg_wo;
  logic [31:0] r_wr_count;

  logic        w_access;
  logic        w_ready;
  logic        w_illegal;
  logic        w_wr_ok;
  logic [3:0]  w_wait_cnt;
  logic [31:0] w_rdata;
  logic        w_unused_wo;

  assign w_access   = p_sel && p_enable;
  // The count only means something inside ACCESS, so every fresh entry starts from zero.
  assign w_wait_cnt = (r_state == StAccess) ? r_wait_cnt : 4'd0;
  assign w_ready    = w_access && (w_wait_cnt == LpWait) && !p_reset;
  assign w_illegal  = p_write ? (p_addr == 2'b00 || p_addr == 2'b11) : (p_addr == 2'b01);
  assign w_wr_ok    = w_ready && p_write && !w_illegal;

  always_comb begin
    w_rdata = '0;
    if (w_ready && !p_write) begin
      case (p_addr)
        2'b00:   w_rdata = r_wr_count;
        2'b10:   w_rdata = r_reg_rw;
        2'b11:   w_rdata = FIXED_VAL;
        default: w_rdata = '0;
      endcase
    end
  end

  always_ff @(posedge p_clk) begin
    if (p_reset) begin
      r_state    <= StIdle;
      r_wait_cnt <= '0;
      r_reg_rw   <= '0;
      r_reg_wo   <= '0;
      r_wr_count <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_access)   r_state <= StAccess;
          else if (p_sel) r_state <= StSetup;
        end
        StSetup: begin
          if (!p_sel)        r_state <= StIdle;
          else if (p_enable) r_state <= StAccess;
        end
        StAccess: begin
          if (!p_sel)         r_state <= StIdle;
          else if (!p_enable) r_state <= StSetup;
        end
        default: r_state <= StIdle;
      endcase
      r_wait_cnt <= (w_access && !w_ready) ? w_wait_cnt + 4'd1 : 4'd0;
      if (w_wr_ok) begin
        if (p_addr == 2'b10) r_reg_rw <= p_w_data;
        if (p_addr == 2'b01) r_reg_wo <= p_w_data;
        r_wr_count <= r_wr_count + 32'd1;
      end
    end
  end

  // Write-only slot has no read path on the bus.
  assign w_unused_wo = ^r_reg_wo;

  assign p_ready  = w_ready;
  assign p_r_data = w_rdata;
`ifdef APB_SLV_ERR_EN
  assign p_slv_err = w_ready && w_illegal;
`else
  assign p_slv_err = 1'b0;
`endif

endmodule

// File: tb/tb_apb_slave.sv
// Bench for apb_slave: a zero-wait and a two-wait instance, directed table, corner sequences
// and random transfers checked against a register-map model.
module tb_apb_slave;

`ifdef APB_SLV_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif
  localparam logic [31:0] FixedVal = 32'hA5A5_5A5A;
  localparam int          Wait2    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel   [2];
  logic        en    [2];
  logic        wr    [2];
  logic [1:0]  addr  [2];
  logic [31:0] wdata [2];
  logic        ready [2];
  logic        err   [2];
  logic [31:0] rdata [2];

  always #5 clk = ~clk;

  apb_slave #(.WAIT_CYCLES(0), .FIXED_VAL(FixedVal)) u_dut0 (
    .p_clk(clk), .p_reset(rst), .p_sel(sel[0]), .p_enable(en[0]), .p_write(wr[0]),
    .p_addr(addr[0]), .p_w_data(wdata[0]), .p_ready(ready[0]), .p_slv_err(err[0]),
    .p_r_data(rdata[0])
  );

  apb_slave #(.WAIT_CYCLES(Wait2), .FIXED_VAL(FixedVal)) u_dut2 (
    .p_clk(clk), .p_reset(rst), .p_sel(sel[1]), .p_enable(en[1]), .p_write(wr[1]),
    .p_addr(addr[1]), .p_w_data(wdata[1]), .p_ready(ready[1]), .p_slv_err(err[1]),
    .p_r_data(rdata[1])
  );

  int n_checks = 0;
  int n_errors = 0;

  // Register-map model, one per instance
  logic [31:0] m_rw  [2];
  logic [31:0] m_cnt [2];

  typedef struct {
    bit          w;
    logic [1:0]  a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  function automatic bit m_illegal(input bit w, input logic [1:0] a);
    return w ? (a == 2'b00 || a == 2'b11) : (a == 2'b01);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 2; i++) begin
      m_rw[i]  = '0;
      m_cnt[i] = '0;
    end
  endtask

  task automatic m_apply(input int d, input bit w, input logic [1:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output bit er);
    er = ErrEn && m_illegal(w, a);
    rd = '0;
    if (w) begin
      if (!m_illegal(w, a)) begin
        if (a == 2'b10) m_rw[d] = wd;
        m_cnt[d] = m_cnt[d] + 32'd1;
      end
    end else begin
      case (a)
        2'b00:   rd = m_cnt[d];
        2'b10:   rd = m_rw[d];
        2'b11:   rd = FixedVal;
        default: rd = '0;
      endcase
    end
  endtask

  task automatic xfer(input int d, input bit w, input logic [1:0] a, input logic [31:0] wd,
                      input bit no_setup, output logic [31:0] rd, output bit er, output int lat);
    lat = -1;
    rd  = '0;
    er  = 1'b0;
    @(posedge clk); #1;
    sel[d] = 1'b1; wr[d] = w; addr[d] = a; wdata[d] = wd; en[d] = no_setup;
    if (!no_setup) begin
      @(posedge clk); #1;
      en[d] = 1'b1;
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (ready[d] === 1'b1) begin
        lat = c;
        rd  = rdata[d];
        er  = err[d];
        break;
      end
      check("wait_quiet", rdata[d] | {31'b0, err[d]}, 32'h0);
      @(posedge clk); #1;
    end
    if (lat < 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL timeout: p_ready never rose within 20 cycles on dut %0d", d);
    end
    @(posedge clk); #1;
    sel[d] = 1'b0; en[d] = 1'b0;
  endtask

  task automatic do_check(input int d, input bit w, input logic [1:0] a, input logic [31:0] wd,
                          input bit no_setup);
    logic [31:0] exp_rd, rd;
    bit          exp_er, er;
    int          lat;
    m_apply(d, w, a, wd, exp_rd, exp_er);
    xfer(d, w, a, wd, no_setup, rd, er, lat);
    check("rdata", rd, exp_rd);
    check("slv_err", {31'b0, er}, {31'b0, exp_er});
    check("latency", lat, (d == 0 || no_setup && d == 0) ? 0 : Wait2);
  endtask

  initial begin
    vec_t        vecs [10];
    logic [31:0] rd, mrd;
    bit          er, mer;
    int          lat;

    vecs[0] = '{1'b1, 2'b10, 32'h10, 32'h0,      1'b0};
    vecs[1] = '{1'b0, 2'b10, 32'h0,  32'h10,     1'b0};
    vecs[2] = '{1'b1, 2'b00, 32'h14, 32'h0,      ErrEn};
    vecs[3] = '{1'b0, 2'b00, 32'h0,  32'h1,      1'b0};
    vecs[4] = '{1'b1, 2'b01, 32'h16, 32'h0,      1'b0};
    vecs[5] = '{1'b0, 2'b01, 32'h0,  32'h0,      ErrEn};
    vecs[6] = '{1'b0, 2'b00, 32'h0,  32'h2,      1'b0};
    vecs[7] = '{1'b1, 2'b11, 32'h14, 32'h0,      ErrEn};
    vecs[8] = '{1'b0, 2'b11, 32'h0,  FixedVal,   1'b0};
    vecs[9] = '{1'b0, 2'b00, 32'h0,  32'h2,      1'b0};

    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sel[i] = 1'b0; en[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
    end
    m_reset();

    // Outputs stay quiet under reset even with a live access phase on the bus
    repeat (3) @(posedge clk);
    #1;
    sel[0] = 1'b1; en[0] = 1'b1; addr[0] = 2'b11;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("reset_ready", {31'b0, ready[i]}, 32'h0);
      check("reset_err", {31'b0, err[i]}, 32'h0);
      check("reset_rdata", rdata[i], 32'h0);
    end
    @(posedge clk); #1;
    sel[0] = 1'b0; en[0] = 1'b0; addr[0] = '0;
    rst = 1'b0;

    // Directed table on the zero-wait instance
    foreach (vecs[i]) begin
      m_apply(0, vecs[i].w, vecs[i].a, vecs[i].wd, mrd, mer);
      xfer(0, vecs[i].w, vecs[i].a, vecs[i].wd, 1'b0, rd, er, lat);
      check("tbl_rdata", rd, vecs[i].exp_rd);
      check("tbl_err", {31'b0, er}, {31'b0, vecs[i].exp_err});
      check("tbl_latency", lat, 0);
    end

    // Zero-setup access straight from idle
    do_check(0, 1'b1, 2'b10, 32'h77, 1'b1);
    do_check(0, 1'b0, 2'b10, 32'h0, 1'b1);

    // Two-wait instance: latency, then an abandoned write
    do_check(1, 1'b1, 2'b10, 32'h55, 1'b0);
    do_check(1, 1'b0, 2'b10, 32'h0, 1'b0);
    @(posedge clk); #1;
    sel[1] = 1'b1; wr[1] = 1'b1; addr[1] = 2'b10; wdata[1] = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    en[1] = 1'b1;
    @(negedge clk);
    check("abandon_ready", {31'b0, ready[1]}, 32'h0);
    @(posedge clk); #1;
    sel[1] = 1'b0; en[1] = 1'b0;
    @(negedge clk);
    check("abandon_idle_ready", {31'b0, ready[1]}, 32'h0);
    do_check(1, 1'b0, 2'b10, 32'h0, 1'b0);
    do_check(1, 1'b0, 2'b00, 32'h0, 1'b0);
    do_check(1, 1'b1, 2'b01, 32'h1234, 1'b0);

    // Reset asserted during the access phase of a write
    @(posedge clk); #1;
    sel[0] = 1'b1; wr[0] = 1'b1; addr[0] = 2'b10; wdata[0] = 32'h0000_BEEF;
    @(posedge clk); #1;
    en[0] = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_ready", {31'b0, ready[0]}, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_hold_ready", {31'b0, ready[0]}, 32'h0);
    @(posedge clk); #1;
    sel[0] = 1'b0; en[0] = 1'b0;
    rst = 1'b0;
    m_reset();
    do_check(0, 1'b0, 2'b10, 32'h0, 1'b0);
    do_check(0, 1'b0, 2'b00, 32'h0, 1'b0);

    // Random traffic on both instances
    for (int i = 0; i < 150; i++) begin
      do_check(0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, 1'b0);
    end
    for (int i = 0; i < 40; i++) begin
      do_check(1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
